// File: rtl/square_share_arbiter_pkg.sv
// Shared constants, state type and squaring reference
// for the square-sharing arbiter.
package sq_pkg;

  localparam int SQ_W     = 3;
  localparam int SQ_RES_W = 2 * SQ_W;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } sq_state_t;

  function automatic logic [SQ_RES_W-1:0] sq_ref(
    input logic [SQ_W-1:0] x
  );
    logic [SQ_RES_W-1:0] xe;
    xe = SQ_RES_W'(x);
    return xe * xe;
  endfunction

endpackage

// File: rtl/square_share_arbiter_if.sv
// Request/response bundle between requester front-ends,
// the square arbiter and the downstream consumer.
interface square_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 3,
  parameter int IDW  = 2
);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [2*W-1:0]    rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_ready;
  logic              busy;

  modport master (
    output req_valid,
    output req_data,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data,
    input  rsp_id,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_data,
    output rsp_id,
    output busy
  );

endinterface

// File: rtl/square_share_arbiter_square_unit.sv
// Combinational squarer: W-bit operand in,
// zero-extended 2*W-bit square out.
module square_unit #(
  parameter int W = 3
) (
  input  logic [W-1:0]   x_i,
  output logic [2*W-1:0] sq_o
);

  localparam int RW = 2 * W;

  logic [RW-1:0] xe;

  assign xe   = RW'(x_i);
  assign sq_o = xe * xe;

endmodule

// File: rtl/square_share_arbiter.sv
// Round-robin arbiter sharing one squarer among NREQ
// requesters, with a single registered response slot.
module square_share_arbiter
  import sq_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = SQ_W,
  parameter int IDW  = $clog2(NREQ)
) (
  input logic                   clk,
  input logic                   rst,
  square_share_arbiter_if.slave bus
);

  sq_state_t state_q, state_d;

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [2*W-1:0] rsp_data_q, rsp_data_d;

  logic [IDW-1:0]  grant_idx;
  logic [IDW-1:0]  grant_nxt;
  logic            grant_found;
  logic            rsp_valid;
  logic            can_accept;
  logic            accept;
  logic            drain;
  logic [W-1:0]    operand;
  logic [2*W-1:0]  square;
  logic [NREQ-1:0] req_ready;
  logic            busy;

  function automatic logic [IDW-1:0] wrap_add(
    input logic [IDW-1:0] p,
    input int             k
  );
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // Search starts at rr_ptr and wraps once around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_found &&
          bus.req_valid[wrap_add(rr_ptr_q, k)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_add(rr_ptr_q, k);
      end
    end
  end

  assign grant_nxt = (grant_idx == IDW'(NREQ - 1))
                   ? '0 : grant_idx + 1'b1;

  assign operand = bus.req_data[int'(grant_idx)*W +: W];

  square_unit #(
    .W (W)
  ) u_sq (
    .x_i  (operand),
    .sq_o (square)
  );

  assign rsp_valid  = (state_q == FULL);
  assign drain      = rsp_valid & bus.rsp_ready;
  assign can_accept = (state_q == EMPTY) | drain;
  // No grant may be issued while reset is held.
  assign accept     = grant_found & can_accept & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) state_d = FULL;
      end
      FULL: begin
        if (drain && !accept) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
    busy = rsp_valid | (|bus.req_valid);
  end

  always_comb begin
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    rr_ptr_d   = rr_ptr_q;
    if (accept) begin
      rsp_data_d = square;
      rsp_id_d   = grant_idx;
      rr_ptr_d   = grant_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
      rr_ptr_q   <= '0;
    end else begin
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.busy      = busy;

`ifndef SYNTHESIS
  a_grant_onehot: assert property (
    @(posedge clk) disable iff (rst)
    $onehot0(bus.req_ready)
  );

  a_rsp_hold: assert property (
    @(posedge clk) disable iff (rst)
    bus.rsp_valid && !bus.rsp_ready |=>
      bus.rsp_valid && $stable(bus.rsp_data)
      && $stable(bus.rsp_id)
  );
`endif

endmodule

// File: tb/tb_square_share_arbiter.sv
// Self-checking bench for square_share_arbiter:
// vector table, directed corner cases, random vs model.
module tb_square_share_arbiter;
  import sq_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 3;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  square_share_arbiter_if #(
    .NREQ (NREQ), .W (W), .IDW (IDW)
  ) bus ();

  square_share_arbiter #(
    .NREQ (NREQ), .W (W), .IDW (IDW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: one response slot plus a pointer.
  bit       m_valid;
  logic [5:0] m_data;
  int       m_id;
  int       m_ptr;

  typedef struct {
    logic [3:0]  rv;
    logic [11:0] rd;
    logic        rr;
    logic [3:0]  ready;
    logic        vld;
    logic [5:0]  data;
    logic [1:0]  id;
  } vec_t;

  vec_t tbl[7];
  logic [5:0] sqtab[8];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] rv,
                              input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (rv[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_id    = 0;
    m_ptr   = 0;
  endtask

  task automatic drive(input logic [3:0] rv,
                       input logic [11:0] rd,
                       input logic rr);
    @(negedge clk);
    bus.req_valid = rv;
    bus.req_data  = rd;
    bus.rsp_ready = rr;
    #1;
  endtask

  task automatic model_check();
    int g;
    logic [3:0] er;
    logic can;
    can = !m_valid || bus.rsp_ready;
    g   = pick(bus.req_valid, m_ptr);
    er  = '0;
    if (can && g >= 0) er[g] = 1'b1;
    chk("m_ready", 32'(bus.req_ready), 32'(er));
    chk("m_valid", 32'(bus.rsp_valid), 32'(m_valid));
    chk("m_busy", 32'(bus.busy),
        32'(m_valid || (|bus.req_valid)));
    if (m_valid) begin
      chk("m_data", 32'(bus.rsp_data), 32'(m_data));
      chk("m_id", 32'(bus.rsp_id), 32'(m_id));
    end
  endtask

  task automatic advance();
    int g;
    logic can;
    int x;
    can = !m_valid || bus.rsp_ready;
    g   = pick(bus.req_valid, m_ptr);
    x   = 0;
    if (g >= 0) x = int'(bus.req_data[g*W +: W]);
    @(posedge clk);
    if (can && g >= 0) begin
      m_valid = 1'b1;
      m_data  = 6'(x * x);
      m_id    = g;
      m_ptr   = (g + 1) % NREQ;
    end else if (m_valid && bus.rsp_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic step(input logic [3:0] rv,
                      input logic [11:0] rd,
                      input logic rr);
    drive(rv, rd, rr);
    model_check();
    advance();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = 4'hF;
    bus.req_data  = 12'hFFF;
    bus.rsp_ready = 1'b1;
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'(0));
    chk("rst_valid", 32'(bus.rsp_valid), 32'(0));
    chk("rst_data", 32'(bus.rsp_data), 32'(0));
    chk("rst_id", 32'(bus.rsp_id), 32'(0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    model_reset();
  endtask

  localparam logic [11:0] RR_DATA =
    {3'd7, 3'd6, 3'd5, 3'd4};

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;
    model_reset();

    sqtab = '{6'd0, 6'd1, 6'd4, 6'd9,
              6'd16, 6'd25, 6'd36, 6'd49};

    tbl[0] = '{4'hF, RR_DATA, 1'b1, 4'b0001, 1'b0, 6'd0, 2'd0};
    tbl[1] = '{4'hF, RR_DATA, 1'b1, 4'b0010, 1'b1, 6'd16, 2'd0};
    tbl[2] = '{4'hF, RR_DATA, 1'b1, 4'b0100, 1'b1, 6'd25, 2'd1};
    tbl[3] = '{4'hF, RR_DATA, 1'b1, 4'b1000, 1'b1, 6'd36, 2'd2};
    tbl[4] = '{4'hF, RR_DATA, 1'b1, 4'b0001, 1'b1, 6'd49, 2'd3};
    tbl[5] = '{4'h0, RR_DATA, 1'b1, 4'b0000, 1'b1, 6'd16, 2'd0};
    tbl[6] = '{4'h0, RR_DATA, 1'b1, 4'b0000, 1'b0, 6'd0, 2'd0};

    // Round-robin rotation straight out of reset.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].rv, tbl[i].rd, tbl[i].rr);
      chk($sformatf("tbl%0d_ready", i),
          32'(bus.req_ready), 32'(tbl[i].ready));
      chk($sformatf("tbl%0d_valid", i),
          32'(bus.rsp_valid), 32'(tbl[i].vld));
      if (tbl[i].vld) begin
        chk($sformatf("tbl%0d_data", i),
            32'(bus.rsp_data), 32'(tbl[i].data));
        chk($sformatf("tbl%0d_id", i),
            32'(bus.rsp_id), 32'(tbl[i].id));
      end
      model_check();
      advance();
    end

    // Reset while FULL and stalled.
    step(4'b0001, 12'o0003, 1'b0);
    step(4'b0000, 12'o0000, 1'b0);
    drive(4'hF, RR_DATA, 1'b0);
    chk("full_valid", 32'(bus.rsp_valid), 32'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(bus.rsp_valid), 32'(0));
    chk("midrst_ready", 32'(bus.req_ready), 32'(0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = '0;
    model_reset();
    drive(4'hF, RR_DATA, 1'b1);
    chk("post_rst_grant", 32'(bus.req_ready), 32'(4'b0001));
    model_check();
    advance();
    step(4'h0, 12'h000, 1'b1);
    step(4'h0, 12'h000, 1'b1);

    // Single request from requester 1.
    drive(4'b0010, 12'o0050, 1'b1);
    chk("single_ready", 32'(bus.req_ready), 32'(4'b0010));
    model_check();
    advance();
    drive(4'b0000, 12'o0000, 1'b1);
    chk("single_valid", 32'(bus.rsp_valid), 32'(1));
    chk("single_data", 32'(bus.rsp_data), 32'(25));
    chk("single_id", 32'(bus.rsp_id), 32'(1));
    model_check();
    advance();

    // Backpressure with two requesters.
    step(4'b0011, 12'o0032, 1'b0);
    for (int c = 0; c < 5; c++) begin
      drive(4'b0011, 12'o0032, 1'b0);
      chk("bp_ready", 32'(bus.req_ready), 32'(0));
      chk("bp_valid", 32'(bus.rsp_valid), 32'(1));
      chk("bp_data", 32'(bus.rsp_data), 32'(m_data));
      chk("bp_id", 32'(bus.rsp_id), 32'(m_id));
      advance();
    end
    for (int c = 0; c < 3; c++) begin
      drive(4'b0011, 12'o0032, 1'b1);
      chk("rel_valid", 32'(bus.rsp_valid), 32'(1));
      chk("rel_grant", 32'(bus.req_ready != 0), 32'(1));
      model_check();
      advance();
    end
    step(4'h0, 12'h000, 1'b1);
    step(4'h0, 12'h000, 1'b1);

    // Every operand through every requester.
    for (int x = 0; x < 8; x++) begin
      for (int i = 0; i < NREQ; i++) begin
        logic [11:0] rd;
        rd = 12'(x) << (i * W);
        step(4'(1 << i), rd, 1'b1);
        drive(4'h0, 12'h000, 1'b1);
        chk("ex_data", 32'(bus.rsp_data), 32'(sqtab[x]));
        chk("ex_ref", 32'(bus.rsp_data),
            32'(sq_ref(3'(x))));
        chk("ex_bit1", 32'(bus.rsp_data[1]), 32'(0));
        chk("ex_id", 32'(bus.rsp_id), 32'(i));
        model_check();
        advance();
      end
    end
    step(4'h0, 12'h000, 1'b1);

    // Early-dropped request while stalled.
    step(4'b0001, 12'o0001, 1'b0);
    step(4'b0000, 12'o0000, 1'b0);
    drive(4'b0100, 12'o0600, 1'b0);
    chk("drop_ready", 32'(bus.req_ready), 32'(0));
    model_check();
    advance();
    step(4'b0000, 12'o0000, 1'b0);
    drive(4'b0000, 12'o0000, 1'b1);
    chk("drop_valid", 32'(bus.rsp_valid), 32'(1));
    advance();
    drive(4'b0000, 12'o0000, 1'b1);
    chk("drop_noextra", 32'(bus.rsp_valid), 32'(0));
    advance();
    drive(4'hF, RR_DATA, 1'b1);
    chk("drop_ptr", 32'(bus.req_ready), 32'(4'b0010));
    model_check();
    advance();
    step(4'h0, 12'h000, 1'b1);
    step(4'h0, 12'h000, 1'b1);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      step(4'($urandom), 12'($urandom),
           ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
